track_splitter: RTL and testbench
=================================

# track_splitter

Record-path counterpart of the playback mixer: takes one mono input sample stream (ADC/line-in strobe) and fans each sample out to every record-armed track, issuing one write per cycle on a shared track-memory write port. Maintains a per-track write pointer, full flags and an overrun counter. Sits between the audio input front end and the track sample BRAM that the playback path later reads.

## Interface
- WIDTH, 16, sample width in bits (signed)
- CHANNELS, 4, number of tracks
- DEPTH, 4096, samples per track buffer (power of two)
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- sample_in  input  WIDTH signed  input sample, valid with sample_valid
- sample_valid  input  1  one-cycle strobe per audio sample; no back-pressure
- arm  input  CHANNELS  per-track record-arm
- clear  input  CHANNELS  per-track pulse: rewind pointer, clear full
- wr_en  output  1  write request to track memory
- wr_channel  output  $clog2(CHANNELS)  target track
- wr_addr  output  $clog2(DEPTH)  sample address within track
- wr_data  output  WIDTH signed  sample to write
- wr_ready  input  1  memory accepts write this cycle when high with wr_en
- full  output  CHANNELS  track buffer full, recording stopped for that track
- busy  output  1  dispatch in progress
- drop_count  output  16  saturating count of overrun samples

## Operation
- FSM states: IDLE, DISPATCH.
- IDLE, sample_valid=1: latch sample_in; pending <= arm & ~full. Pending nonzero -> DISPATCH. Pending zero -> stay IDLE, sample discarded, not counted.
- DISPATCH: wr_en=1; wr_channel = lowest set bit of pending; wr_addr = ptr[wr_channel]; wr_data = latched sample.
- Handshake wr_en && wr_ready: clear that pending bit; ptr[ch] <= ptr[ch]+1; if ptr[ch] was DEPTH-1, full[ch] <= 1 and ptr[ch] <= 0 (no further writes to that track until cleared).
- wr_ready low: hold wr_channel/wr_addr/wr_data stable; no state change.
- Last pending bit handshakes -> IDLE next cycle.
- sample_valid while in DISPATCH (including the final-handshake cycle): sample dropped; drop_count <= drop_count+1, saturating at 16'hFFFF.
- arm changes during DISPATCH do not affect current pending snapshot.
- clear[i]: ptr[i] <= 0, full[i] <= 0 next cycle. Wins over a simultaneous handshake on track i. If track i still pending, its write proceeds at address 0.
- No scaling or arithmetic on samples; wr_data is bit-exact copy of sample_in.
- busy = (state == DISPATCH).

## Timing
- All outputs derived from registers only; no combinational input-to-output paths.
- Reset (async assert, sync release): state IDLE, pending 0, all ptr 0, full 0, drop_count 0, wr_en 0, wr_channel 0, wr_addr 0, wr_data 0, busy 0.
- Latency: sample_valid at cycle t -> first wr_en at t+1.
- N armed, wr_ready held high: writes at t+1..t+N, IDLE at t+N+1, next sample accepted from t+N+1.
- Throughput requirement at system level: sample period > CHANNELS+1 cycles with no memory stall.
- Reset mid-dispatch: pending writes abandoned, wr_en low immediately.

## Structure
- Shared daw_pkg: sample_t (logic signed [15:0]), splitter_state_t enum {IDLE, DISPATCH}, DEFAULT_TRACK_DEPTH constant.
- One sub-module: lowest_set_index (parameterized CHANNELS-wide priority encoder, outputs index and any-set flag).
- Pointer array and full flags live in track_splitter.

## Test plan
- Reset, arm=4'b1011, sample_in=16'sh1234 strobe, wr_ready=1 -> writes (ch0,a0),(ch1,a0),(ch3,a0) on cycles t+1..t+3, data 16'sh1234; busy low at t+4.
- Same with wr_ready low for 2 cycles during ch1 write -> ch1 held stable 2 extra cycles, no duplicate write, total 5 wr_en cycles.
- DEPTH=8, arm=4'b0001, 9 strobes -> addresses 0..7 written, full[0]=1 after 8th, 9th sample produces no write and no drop count.
- arm=4'b1111, second strobe 2 cycles after first -> second sample dropped, drop_count=1; 65536 forced overruns -> drop_count stays 16'hFFFF.
- full[2]=1, pulse clear[2] -> full[2]=0, next armed sample written to (ch2,a0); clear[1] coinciding with ch1 handshake -> ptr[1]=0.
- arm=4'b0000 strobe -> no wr_en, drop_count unchanged; assert rst_in during DISPATCH -> wr_en low that cycle, all pointers 0.

Source files
------------

// File: rtl/daw_pkg.sv
// Shared types and constants for the DAW record/playback datapath.
package daw_pkg;

  localparam int SAMPLE_W            = 16;
  localparam int DEFAULT_TRACK_DEPTH = 4096;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    DISPATCH = 1'b1
  } splitter_state_t;

  // Saturating 16-bit increment used by event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lowest_set_index.sv
// Priority encoder: index of the lowest set bit of vec, plus an any-set flag.
module lowest_set_index #(
  parameter int N = 4
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = vec[i] ? IW'(i) : idx;
    end
  end

  assign any = |vec;

endmodule

// File: rtl/track_splitter.sv
// Fans each input sample out to every record-armed track, one write per cycle
// on a shared track-memory port, with per-track pointers, full flags and overrun count.
module track_splitter
  import daw_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = DEFAULT_TRACK_DEPTH
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic signed [WIDTH-1:0]     sample_in,
  input  logic                        sample_valid,
  input  logic [CHANNELS-1:0]         arm,
  input  logic [CHANNELS-1:0]         clear,
  output logic                        wr_en,
  output logic [$clog2(CHANNELS)-1:0] wr_channel,
  output logic [$clog2(DEPTH)-1:0]    wr_addr,
  output logic signed [WIDTH-1:0]     wr_data,
  input  logic                        wr_ready,
  output logic [CHANNELS-1:0]         full,
  output logic                        busy,
  output logic [15:0]                 drop_count
);

  localparam int CW = $clog2(CHANNELS);
  localparam int AW = $clog2(DEPTH);

  splitter_state_t         state_r, state_nxt_s;
  logic [CHANNELS-1:0]     pending_r, pending_nxt_s;
  logic signed [WIDTH-1:0] sample_r, sample_nxt_s;
  logic [AW-1:0]           ptr_r     [CHANNELS];
  logic [AW-1:0]           ptr_upd_s [CHANNELS];
  logic [AW-1:0]           ptr_nxt_s [CHANNELS];
  logic [CHANNELS-1:0]     full_r, full_upd_s, full_nxt_s;
  logic [15:0]             drop_r, drop_nxt_s;
  logic [CW-1:0]           wr_channel_r;
  logic [AW-1:0]           wr_addr_r, wr_addr_nxt_s;
  logic [CW-1:0]           next_idx_s;
  logic                    next_any_s;

  // Next-state, pending snapshot, pointer advance and overrun accounting.
  always_comb begin
    state_nxt_s   = state_r;
    pending_nxt_s = pending_r;
    sample_nxt_s  = sample_r;
    ptr_upd_s     = ptr_r;
    full_upd_s    = full_r;
    drop_nxt_s    = drop_r;
    case (state_r)
      IDLE: begin
        if (sample_valid) begin
          sample_nxt_s  = sample_in;
          pending_nxt_s = arm & ~full_r;
          if (|(arm & ~full_r)) begin
            state_nxt_s = DISPATCH;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DISPATCH: begin
        if (wr_ready) begin
          pending_nxt_s[wr_channel_r] = 1'b0;
          // Last slot of the buffer: stop this track and rewind.
          if (ptr_r[wr_channel_r] == AW'(DEPTH - 1)) begin
            full_upd_s[wr_channel_r] = 1'b1;
            ptr_upd_s[wr_channel_r]  = '0;
          end else begin
            ptr_upd_s[wr_channel_r]  = ptr_r[wr_channel_r] + AW'(1);
          end
        end else begin
          pending_nxt_s = pending_r;
        end
        if (sample_valid) begin
          drop_nxt_s = sat_inc16(drop_r);
        end else begin
          drop_nxt_s = drop_r;
        end
        if (pending_nxt_s == '0) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DISPATCH;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        pending_nxt_s = '0;
      end
    endcase
  end

  // Per-track clear overrides any handshake update on the same track.
  always_comb begin
    ptr_nxt_s  = ptr_upd_s;
    full_nxt_s = full_upd_s;
    for (int i = 0; i < CHANNELS; i++) begin
      if (clear[i]) begin
        ptr_nxt_s[i]  = '0;
        full_nxt_s[i] = 1'b0;
      end else begin
        ptr_nxt_s[i]  = ptr_upd_s[i];
        full_nxt_s[i] = full_upd_s[i];
      end
    end
  end

  lowest_set_index #(
    .N (CHANNELS)
  ) u_lowest (
    .vec (pending_nxt_s),
    .idx (next_idx_s),
    .any (next_any_s)
  );

  assign wr_addr_nxt_s = next_any_s ? ptr_nxt_s[next_idx_s] : '0;

  // State, datapath and registered write-port outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r      <= IDLE;
      pending_r    <= '0;
      sample_r     <= '0;
      full_r       <= '0;
      drop_r       <= 16'h0000;
      wr_channel_r <= '0;
      wr_addr_r    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        ptr_r[i] <= '0;
      end
    end else begin
      state_r      <= state_nxt_s;
      pending_r    <= pending_nxt_s;
      sample_r     <= sample_nxt_s;
      full_r       <= full_nxt_s;
      drop_r       <= drop_nxt_s;
      wr_channel_r <= next_idx_s;
      wr_addr_r    <= wr_addr_nxt_s;
      for (int i = 0; i < CHANNELS; i++) begin
        ptr_r[i] <= ptr_nxt_s[i];
      end
    end
  end

  assign wr_en      = (state_r == DISPATCH);
  assign busy       = (state_r == DISPATCH);
  assign wr_channel = wr_channel_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = sample_r;
  assign full       = full_r;
  assign drop_count = drop_r;

endmodule

// File: tb/tb_track_splitter.sv
// Scoreboard bench for track_splitter: a per-sample reference model queues expected
// writes; a negedge monitor compares every presented write against the queue head.
module tb_track_splitter;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int D  = 8;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic [3:0]         arm;
  logic [3:0]         clear;
  logic               wr_en;
  logic [1:0]         wr_channel;
  logic [2:0]         wr_addr;
  logic signed [15:0] wr_data;
  logic               wr_ready;
  logic [3:0]         full;
  logic               busy;
  logic [15:0]        drop_count;

  track_splitter #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .arm          (arm),
    .clear        (clear),
    .wr_en        (wr_en),
    .wr_channel   (wr_channel),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .full         (full),
    .busy         (busy),
    .drop_count   (drop_count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          ch;
    int          addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  wr_cycles = 0;
  int  m_ptr [CH];
  bit  m_full [CH];
  int  m_drop;
  int  last_n;
  bit  rand_ready = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_ptr[c]  = 0;
      m_full[c] = 1'b0;
    end
    m_drop = 0;
    exp_q.delete();
  endfunction

  // One accepted sample: every armed, non-full track in ascending order gets a write.
  function automatic int model_accept(input logic [3:0] a, input logic [15:0] d);
    int n = 0;
    for (int c = 0; c < CH; c++) begin
      if (a[c] && !m_full[c]) begin
        wr_t e;
        e.ch = c; e.addr = m_ptr[c]; e.data = d;
        exp_q.push_back(e);
        m_ptr[c] = (m_ptr[c] + 1) % D;
        if (m_ptr[c] == 0) m_full[c] = 1'b1;
        n++;
      end
    end
    return n;
  endfunction

  function automatic void model_clear(input logic [3:0] mask);
    for (int c = 0; c < CH; c++) begin
      if (mask[c]) begin
        m_ptr[c]  = 0;
        m_full[c] = 1'b0;
      end
    end
  endfunction

  function automatic int model_full();
    int f = 0;
    for (int c = 0; c < CH; c++) if (m_full[c]) f |= (1 << c);
    return f;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
    if (rand_ready) wr_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL %s: busy still %0d after %0d cycles, expected 0", tag, busy, n);
    end
  endtask

  task automatic strobe(input logic [3:0] a, input logic [15:0] d, input bit dropped);
    arm = a;
    sample_in = d;
    sample_valid = 1'b1;
    if (dropped) begin
      if (m_drop < 65535) m_drop++;
      last_n = 0;
    end else begin
      last_n = model_accept(a, d);
    end
    step();
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    arm = '0;
    clear = '0;
    wr_ready = 1'b0;
    step();
    step();
    model_reset();
    rst_in = 1'b0;
    step();
  endtask

  // Monitor: every presented write must match the head of the expected queue.
  always @(negedge clk_in) begin
    if (!rst_in && wr_en) begin
      wr_cycles++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got ch=%0d addr=%0d, expected no write", wr_channel, wr_addr);
      end else begin
        chk("wr_channel", int'(wr_channel), exp_q[0].ch);
        chk("wr_addr", int'(wr_addr), exp_q[0].addr);
        chk("wr_data", int'({16'h0000, wr_data}), int'({16'h0000, exp_q[0].data}));
        if (wr_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    do_reset();
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_drop", int'(drop_count), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_channel", int'(wr_channel), 0);
    chk("rst_wr_data", int'({16'h0000, wr_data}), 0);

    // Basic fan-out with one-cycle latency.
    wr_ready = 1'b1;
    strobe(4'b1011, 16'h1234, 1'b0);
    chk("lat_wr_en", int'(wr_en), 1);
    chk("t1_ch", int'(wr_channel), 0);
    step();
    chk("t2_ch", int'(wr_channel), 1);
    step();
    chk("t3_ch", int'(wr_channel), 3);
    step();
    chk("t4_busy", int'(busy), 0);
    chk("t4_wr_en", int'(wr_en), 0);

    // Two-cycle stall during the ch1 write.
    c0 = wr_cycles;
    strobe(4'b1011, 16'h5A5A, 1'b0);
    step();
    wr_ready = 1'b0;
    step();
    chk("stall_hold_ch", int'(wr_channel), 1);
    step();
    wr_ready = 1'b1;
    step();
    chk("stall_ch3", int'(wr_channel), 3);
    step();
    chk("stall_idle", int'(busy), 0);
    chk("stall_wr_cycles", wr_cycles - c0, 5);

    // Fill track 0, then one more sample that must be ignored.
    do_reset();
    wr_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      wait_idle("fill_wait");
      if (k == 8) chk("full_after_8", int'(full), 1);
      strobe(4'b0001, 16'($urandom), 1'b0);
    end
    wait_idle("fill_end");
    step();
    chk("full_9th_drop", int'(drop_count), 0);
    chk("full_9th_full", int'(full), 1);

    // Overrun during dispatch, then saturation.
    do_reset();
    wr_ready = 1'b1;
    strobe(4'b1111, 16'h0F0F, 1'b0);
    step();
    strobe(4'b1111, 16'h7777, 1'b1);
    wait_idle("drop_wait");
    chk("drop_one", int'(drop_count), m_drop);
    wr_ready = 1'b0;
    strobe(4'b1111, 16'hBEEF, 1'b0);
    sample_valid = 1'b1;
    for (int k = 0; k < 65540; k++) begin
      if (m_drop < 65535) m_drop++;
      step();
    end
    sample_valid = 1'b0;
    wr_ready = 1'b1;
    wait_idle("sat_wait");
    chk("drop_saturated", int'(drop_count), 65535);

    // Clear a full track, and clear coinciding with a handshake.
    do_reset();
    wr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_idle("clr_fill");
      strobe(4'b0100, 16'($urandom), 1'b0);
    end
    wait_idle("clr_fill_end");
    chk("clr_full_set", int'(full), 4);
    clear = 4'b0100;
    model_clear(4'b0100);
    step();
    clear = 4'b0000;
    chk("clr_full_cleared", int'(full), 0);
    strobe(4'b0100, 16'h2222, 1'b0);
    wait_idle("clr_rewrite");
    for (int k = 0; k < 3; k++) begin
      strobe(4'b0010, 16'($urandom), 1'b0);
      wait_idle("clr_ch1");
    end
    strobe(4'b0011, 16'h3333, 1'b0);
    step();
    clear = 4'b0010;
    step();
    clear = 4'b0000;
    model_clear(4'b0010);
    wait_idle("clr_coinc");
    strobe(4'b0010, 16'h4444, 1'b0);
    wait_idle("clr_after");

    // Nothing armed, then reset mid-dispatch.
    c0 = int'(drop_count);
    strobe(4'b0000, 16'h5555, 1'b0);
    chk("noarm_wr_en", int'(wr_en), 0);
    chk("noarm_drop", int'(drop_count), c0);
    strobe(4'b1111, 16'h6666, 1'b0);
    step();
    rst_in = 1'b1;
    #1;
    chk("rst_mid_wr_en", int'(wr_en), 0);
    model_reset();
    step();
    rst_in = 1'b0;
    step();
    chk("rst_mid_addr", int'(wr_addr), 0);
    strobe(4'b1111, 16'h7A7A, 1'b0);
    wait_idle("rst_mid_after");

    // Randomized traffic with memory stalls, clears and overruns.
    rand_ready = 1'b1;
    for (int it = 0; it < 300; it++) begin
      wait_idle("rand_wait");
      chk("rand_full", int'(full), model_full());
      chk("rand_drop", int'(drop_count), m_drop);
      if ($urandom_range(0, 7) == 0) begin
        clear = 4'($urandom);
        model_clear(clear);
        step();
        clear = 4'b0000;
      end else begin
        strobe(4'($urandom), 16'($urandom), 1'b0);
        if (last_n > 0 && $urandom_range(0, 3) == 0) begin
          strobe(4'($urandom), 16'($urandom), 1'b1);
        end
      end
    end
    rand_ready = 1'b0;
    wr_ready = 1'b1;
    wait_idle("final_wait");
    step();
    chk("final_drop", int'(drop_count), m_drop);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
